// File: rtl/ex_div_unit.sv
// Iterative 32-bit restoring divider for div.w/div.wu/mod.w/mod.wu in EX.
// 33 cycles from accepted request to div_done; result held until div_ack, flush aborts.
module ex_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_ack,
  input  logic        div_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quo,
  output logic [31:0] div_rem
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] prem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] src1_raw;
  logic [4:0]  cnt;
  logic        q_neg, r_neg, div0;

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial, prem_nxt;
  logic        qbit;
  logic [31:0] dvd_nxt, quo_fin, rem_fin;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_req) state_d = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_d = S_DONE;
      S_DONE:  if (div_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (div_flush) state_d = S_IDLE;
  end

  // Operand magnitudes; only signed ops get the absolute value.
  always_comb begin
    a_mag = (div_signed & div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
    b_mag = (div_signed & div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;
  end

  // One restoring step: shift in the next dividend bit, try to subtract divisor.
  always_comb begin
    shifted  = {prem[31:0], dvd[31]};
    trial    = shifted - {1'b0, dvs};
    qbit     = ~trial[32];
    prem_nxt = qbit ? trial : shifted;
    dvd_nxt  = {dvd[30:0], qbit};
    quo_fin  = div0 ? 32'hFFFF_FFFF : (q_neg ? (~dvd_nxt + 32'd1) : dvd_nxt);
    rem_fin  = div0 ? src1_raw
                    : (r_neg ? (~prem_nxt[31:0] + 32'd1) : prem_nxt[31:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prem     <= '0;
      dvd      <= '0;
      dvs      <= '0;
      src1_raw <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div0     <= 1'b0;
      div_quo  <= '0;
      div_rem  <= '0;
    end else if (!div_flush) begin
      case (state_q)
        S_IDLE: if (div_req) begin
          dvd      <= a_mag;
          dvs      <= b_mag;
          src1_raw <= div_src1;
          q_neg    <= div_signed & (div_src1[31] ^ div_src2[31]);
          r_neg    <= div_signed & div_src1[31];
          div0     <= (div_src2 == 32'd0);
          prem     <= '0;
          cnt      <= '0;
        end
        S_RUN: begin
          prem <= prem_nxt;
          dvd  <= dvd_nxt;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            div_quo <= quo_fin;
            div_rem <= rem_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_busy = (state_q == S_RUN) | ((state_q == S_IDLE) & div_req & ~div_flush);
  assign div_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized and directed bench for ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        reset, div_req, div_signed, div_ack, div_flush;
  logic [31:0] div_src1, div_src2;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  int n_vec = 0;
  int n_err = 0;

  ex_div_unit dut (
    .clk(clk), .reset(reset), .div_req(div_req), .div_signed(div_signed),
    .div_src1(div_src1), .div_src2(div_src2), .div_ack(div_ack),
    .div_flush(div_flush), .div_busy(div_busy), .div_done(div_done),
    .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the team's divide-by-zero rule.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue a request, wait for div_done (checking the 33-cycle latency and busy),
  // optionally hold the result for hold cycles while scrambling operands, then ack.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic noise);
    logic [31:0] eq, er;
    int cyc;
    model(sgn, a, b, eq, er);
    div_signed = sgn; div_src1 = a; div_src2 = b; div_req = 1'b1; div_ack = 1'b0;
    #1;
    chk("busy_at_req", {31'd0, div_busy}, 32'd1);
    cyc = 0;
    while (!div_done && cyc < 40) begin
      step();
      cyc++;
      if (noise) begin
        div_src1 = $urandom; div_src2 = $urandom; div_signed = 1'($urandom);
        div_ack = div_done ? 1'b0 : 1'($urandom);
      end
      if (!div_done && cyc < 33) chk("busy_run", {31'd0, div_busy}, 32'd1);
    end
    chk("latency", cyc, 33);
    div_ack = 1'b0;
    #1;
    chk("quo", div_quo, eq);
    chk("rem", div_rem, er);
    for (int i = 0; i < hold; i++) begin
      div_src1 = $urandom; div_src2 = $urandom; div_signed = ~div_signed;
      step();
      chk("hold_done", {31'd0, div_done}, 32'd1);
      chk("hold_quo", div_quo, eq);
      chk("hold_rem", div_rem, er);
    end
    div_ack = 1'b1;
    step();
    chk("ack_idle", {31'd0, div_done}, 32'd0);
    div_req = 1'b0; div_ack = 1'b0;
    #1;
    chk("idle_busy", {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er, held_q;
    reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; div_ack = 1'b0; div_flush = 1'b0;
    div_src1 = '0; div_src2 = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    chk("rst_quo", div_quo, 32'd0);
    chk("rst_rem", div_rem, 32'd0);

    run_op(1'b0, 32'd7, 32'd2, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h8765_4321, 32'd0, 0, 1'b0);
    run_op(1'b0, 32'd1000, 32'd33, 5, 1'b0);

    // Flush mid-run, then restart immediately with 100/7.
    div_signed = 1'b0; div_src1 = 32'hDEAD_BEEF; div_src2 = 32'd3; div_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("flush_nodone", {31'd0, div_done}, 32'd0);
    end
    div_flush = 1'b1;
    step();
    div_flush = 1'b0;
    chk("flush_done", {31'd0, div_done}, 32'd0);
    div_req = 1'b0;
    #1;
    chk("flush_idle", {31'd0, div_busy}, 32'd0);
    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);

    // Reset 20 cycles into a run.
    div_signed = 1'b1; div_src1 = 32'hF000_0001; div_src2 = 32'd5; div_req = 1'b1;
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0; div_req = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, div_done}, 32'd0);
    chk("mid_rst_quo", div_quo, 32'd0);
    chk("mid_rst_rem", div_rem, 32'd0);

    // Flush and ack together in DONE: back to IDLE, stored result untouched.
    model(1'b0, 32'd50, 32'd6, eq, er);
    div_signed = 1'b0; div_src1 = 32'd50; div_src2 = 32'd6; div_req = 1'b1;
    for (int i = 0; i < 40 && !div_done; i++) step();
    chk("fa_done", {31'd0, div_done}, 32'd1);
    held_q = div_quo;
    chk("fa_quo", held_q, eq);
    div_flush = 1'b1; div_ack = 1'b1;
    step();
    div_flush = 1'b0; div_ack = 1'b0; div_req = 1'b0;
    #1;
    chk("fa_idle_done", {31'd0, div_done}, 32'd0);
    chk("fa_idle_busy", {31'd0, div_busy}, 32'd0);
    chk("fa_quo_kept", div_quo, eq);
    chk("fa_rem_kept", div_rem, er);

    // Random operations with input noise and stray acks during RUN.
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b & 32'h0000_00FF;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(1'($urandom), a, b, $urandom_range(0, 2), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit divider with its own sequencing FSM, serving the EX stage for div.w, div.wu, mod.w and mod.wu. EX raises a request when a valid divide/modulo instruction reaches it. It holds EX_ReadyGo low until div_done is asserted, then takes the quotient or the remainder. One request is in flight at a time. A pipeline flush aborts the operation.

## Interface
Parameters: none (width fixed at 32, latency fixed).

- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- div_req  in  1  EX holds a valid div/mod instruction; stays high until EX accepts the result
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned; sampled with div_req in IDLE
- div_src1  in  32  dividend (rj_value); sampled in IDLE
- div_src2  in  32  divisor (rkd_value); sampled in IDLE
- div_ack  in  1  EX is passing the instruction to ME this cycle (EX_ReadyGo & ME_Allow_in)
- div_flush  in  1  pipeline flush; aborts any operation
- div_busy  out  1  operation accepted and result not yet ready
- div_done  out  1  div_quo/div_rem are valid and held
- div_quo  out  32  quotient
- div_rem  out  32  remainder

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE, with div_req=1 and div_flush=0:
  - latch |src1| and |src2|; magnitudes are taken only when div_signed=1
  - latch q_neg = signed & (src1[31]^src2[31]) and r_neg = signed & src1[31]
  - latch div0 = (src2==0) and the raw src1
  - clear the 33-bit partial remainder and the 5-bit counter
  - go to RUN
- RUN: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude (33-bit). If it does not go negative, keep the difference and set quotient bit = 1; otherwise set the bit to 0.
  - Counter increments each cycle. On the step with counter==31, compute the final result into div_quo/div_rem and go to DONE.
- Sign fixup:
  - quo = q_neg ? -q_mag : q_mag
  - rem = r_neg ? -r_mag : r_mag
  - All negation is 32-bit two's complement with wrap.
- Divide by zero (div0=1): quo = 32'hFFFF_FFFF and rem = raw src1, for both signed and unsigned. This is the team-defined result; the ISA leaves it unspecified.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives quo = 0x8000_0000, rem = 0. This falls out of the magnitude arithmetic and needs no special case.
- DONE:
  - div_done=1; div_quo/div_rem are held stable.
  - div_ack=1 returns to IDLE next cycle.
  - Without div_ack, the block stays in DONE indefinitely; it never re-samples operands here.
- Flush: in any state, div_flush=1 returns the FSM to IDLE next cycle. Flush beats div_req and div_ack in the same cycle. Partial results are discarded and outputs are not updated.
- div_busy = (state==RUN) | (state==IDLE & div_req & ~div_flush).
- div_done = (state==DONE), a registered state decode.

## Timing
- Reset values: state IDLE, div_busy 0, div_done 0, div_quo 0, div_rem 0, counter 0.
- Latency, with the request sampled in IDLE at cycle T:
  - RUN during T+1 … T+32
  - div_done=1 from T+33
  - total 33 cycles from the first div_req to div_done
- Back-to-back: ack at DONE cycle D gives IDLE at D+1. A new div_req seen at D+1 gives div_done at D+34.
- Operands are sampled only in IDLE. Changes on div_src1/div_src2/div_signed during RUN or DONE have no effect.
- Reset mid-operation: IDLE next cycle and all outputs return to reset values.
- div_ack outside DONE is ignored.

## Test plan
- Unsigned: signed=0, src1=7, src2=2 -> div_done at T+33 with quo=3, rem=1. div_busy is high T … T+32.
- Signed negatives:
  - signed=1, src1=0xFFFF_FFF9 (-7), src2=2 -> quo=0xFFFF_FFFD, rem=0xFFFF_FFFF
  - src1=7, src2=0xFFFF_FFFE -> quo=0xFFFF_FFFD, rem=1
- Corners:
  - signed, 0x8000_0000 / 0xFFFF_FFFF -> quo=0x8000_0000, rem=0
  - unsigned, 0xFFFF_FFFF / 1 -> quo=0xFFFF_FFFF, rem=0
  - src2=0, src1=0x1234_5678, either mode -> quo=0xFFFF_FFFF, rem=0x1234_5678
- Flush and restart: flush at T+10 -> IDLE at T+11 with div_done never asserted. New request 100/7 at T+11 -> quo=14, rem=2 at T+44.
- Held result: withhold div_ack for 5 cycles in DONE while toggling the src inputs -> quo/rem unchanged. Ack -> IDLE next cycle.
- Reset and simultaneous events:
  - reset at T+20 -> all outputs 0 next cycle
  - flush and ack together in DONE -> IDLE, with flush given priority
